// File: rtl/ct_fcnvt_pkg.sv
// Shared definitions for the FP16->FP32 convert sequencer: FSM encoding,
// exponent rebias constants, lane widths and fflags bit positions.
// Pure declarations; no logic, no latency, no flow control.
package ct_fcnvt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } htos_state_e;

  localparam int LANES  = 4;
  localparam int HALF_W = 16;
  localparam int SNGL_W = 32;

  // FP32 bias (127) minus FP16 bias (15) for normals.
  localparam logic [7:0] EXP_BIAS_NORM  = 8'd112;
  // Subnormal value f * 2^-24: leading one at bit k gives exponent 127-24+k.
  localparam logic [7:0] EXP_BIAS_DNORM = 8'd103;

  // fflags vector {NV,DZ,OF,UF,NX}
  localparam int FFLAG_NX = 0;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_NV = 4;

endpackage

// File: rtl/ct_fcnvt_htos_dnorm.sv
// Leading-one normalizer turning an FP16 subnormal fraction into FP32 exp/frac.
// Purely combinational, zero latency.
// No flow control; caller steers one lane per cycle.
module ct_fcnvt_htos_dnorm
  import ct_fcnvt_pkg::*;
(
  input  logic [9:0]  frac_i,
  output logic [7:0]  exp_o,
  output logic [22:0] frac_o
);

  logic [3:0] lead;
  logic [4:0] shamt;

  // Find the leading one, then shift it out past bit 22 so the bits below it
  // end up left-justified; the conversion is exact so nothing is rounded.
  always_comb begin
    lead = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (frac_i[i]) lead = 4'(i);
    end
    shamt  = 5'd23 - {1'b0, lead};
    exp_o  = EXP_BIAS_DNORM + {4'b0, lead};
    frac_o = {13'b0, frac_i} << shamt;
  end

endmodule

// File: rtl/ct_fcnvt_htos_seq.sv
// Packed 4-lane FP16->FP32 convert sequencer; subnormal lanes share one normalizer.
// Latency: accept at T -> out_vld at T+1+D (D = enabled subnormal lanes).
// Backpressure: in_rdy only in IDLE; result held while out_vld && !out_rdy.
// Optional NV flag output enabled by macro FCNVT_HTOS_FFLAGS_EN.
module ct_fcnvt_htos_seq (
  input  logic         forever_cpuclk,
  input  logic         cpurst,
  input  logic         cnvt_flush,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [63:0]  in_data,
  input  logic [3:0]   in_lane_en,
  output logic         out_vld,
  input  logic         out_rdy,
`ifdef FCNVT_HTOS_FFLAGS_EN
  output logic [4:0]   out_fflags,
`endif
  output logic [127:0] out_data
);

  import ct_fcnvt_pkg::*;

  htos_state_e state_q;
  logic [LANES-1:0]        pend_q;
  logic [LANES-1:0]        pend_d;
  logic [LANES*SNGL_W-1:0] res_q;
  logic [LANES*SNGL_W-1:0] res_d;
  logic [LANES*11-1:0]     src_q;   // per lane {sign, frac[9:0]}
  logic [LANES*11-1:0]     src_d;
  logic                    out_vld_q;
  logic                    nv_d;
`ifdef FCNVT_HTOS_FFLAGS_EN
  logic                    nv_q;
`endif

  logic [1:0]       sel_idx;
  logic [LANES-1:0] sel_oh;
  logic             sel_sgn;
  logic [9:0]       sel_frac;
  logic [7:0]       dn_exp;
  logic [22:0]      dn_frac;
  logic             accept;

  assign in_rdy   = (state_q == ST_IDLE) && !cnvt_flush && !cpurst;
  assign accept   = in_vld && in_rdy;
  assign out_vld  = out_vld_q;
  assign out_data = res_q;

  // Single-cycle conversion of the non-subnormal lanes; subnormals are marked pending.
  always_comb begin
    res_d  = '0;
    pend_d = '0;
    src_d  = '0;
    nv_d   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      logic       s;
      logic [4:0] e;
      logic [9:0] f;
      s = in_data[i*HALF_W + 15];
      e = in_data[i*HALF_W + 10 +: 5];
      f = in_data[i*HALF_W +: 10];
      src_d[i*11 +: 11] = {s, f};
      if (in_lane_en[i]) begin
        if (e == 5'd0) begin
          if (f == 10'd0) res_d[i*SNGL_W +: SNGL_W] = {s, 31'b0};
          else            pend_d[i] = 1'b1;
        end else if (e == 5'd31) begin
          if (f == 10'd0) begin
            res_d[i*SNGL_W +: SNGL_W] = {s, 8'hFF, 23'b0};
          end else begin
            res_d[i*SNGL_W +: SNGL_W] = {s, 8'hFF, 1'b1, f[8:0], 13'b0};
            if (!f[9]) nv_d = 1'b1;
          end
        end else begin
          res_d[i*SNGL_W +: SNGL_W] = {s, {3'b0, e} + EXP_BIAS_NORM, f, 13'b0};
        end
      end
    end
  end

  // Lowest-index pending lane wins the shared normalizer.
  always_comb begin
    sel_idx = 2'd0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_idx = 2'(i);
    end
    sel_oh   = 4'b0001 << sel_idx;
    sel_sgn  = src_q[11*sel_idx + 10];
    sel_frac = src_q[11*sel_idx +: 10];
  end

  ct_fcnvt_htos_dnorm u_dnorm (
    .frac_i (sel_frac),
    .exp_o  (dn_exp),
    .frac_o (dn_frac)
  );

  // Sequencer FSM with registered result, pending mask and valid.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      res_q     <= '0;
      src_q     <= '0;
      out_vld_q <= 1'b0;
`ifdef FCNVT_HTOS_FFLAGS_EN
      nv_q      <= 1'b0;
`endif
    end else if (cnvt_flush) begin
      // A result pending in the flush cycle is dropped, even if out_rdy is high.
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      out_vld_q <= 1'b0;
`ifdef FCNVT_HTOS_FFLAGS_EN
      nv_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            res_q  <= res_d;
            src_q  <= src_d;
            pend_q <= pend_d;
`ifdef FCNVT_HTOS_FFLAGS_EN
            nv_q   <= nv_d;
`endif
            if (pend_d != '0) begin
              state_q <= ST_SCAN;
            end else begin
              state_q   <= ST_DONE;
              out_vld_q <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          res_q[{sel_idx, 5'b0} +: SNGL_W] <= {sel_sgn, dn_exp, dn_frac};
          pend_q <= pend_q & ~sel_oh;
          if (pend_q == sel_oh) begin
            state_q   <= ST_DONE;
            out_vld_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_rdy) begin
            state_q   <= ST_IDLE;
            out_vld_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FCNVT_HTOS_FFLAGS_EN
  // Only NV can arise from an exact widening conversion.
  always_comb begin
    out_fflags           = '0;
    out_fflags[FFLAG_NV] = nv_q;
  end
`else
  // Signaling-NaN detection has no consumer without the flags port.
  logic unused_nv;
  assign unused_nv = nv_d;
`endif

endmodule

// File: tb/tb_ct_fcnvt_htos_seq.sv
module tb_ct_fcnvt_htos_seq;

  logic         clk = 1'b0;
  logic         cpurst;
  logic         cnvt_flush;
  logic         in_vld;
  logic         in_rdy;
  logic [63:0]  in_data;
  logic [3:0]   in_lane_en;
  logic         out_vld;
  logic         out_rdy;
  logic [127:0] out_data;
`ifdef FCNVT_HTOS_FFLAGS_EN
  logic [4:0]   out_fflags;
`endif

  int checks = 0;
  int errors = 0;

  ct_fcnvt_htos_seq dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .cnvt_flush     (cnvt_flush),
    .in_vld         (in_vld),
    .in_rdy         (in_rdy),
    .in_data        (in_data),
    .in_lane_en     (in_lane_en),
    .out_vld        (out_vld),
    .out_rdy        (out_rdy),
`ifdef FCNVT_HTOS_FFLAGS_EN
    .out_fflags     (out_fflags),
`endif
    .out_data       (out_data)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [63:0]  dat;
    logic [3:0]   en;
    logic [127:0] exp_dat;
    int           d;
    logic         nv;
    int           stall;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns with in_rdy high, or logs a failure after a bounded wait.
  task automatic wait_rdy(input string nm);
    int n = 0;
    while (!in_rdy && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_rdy_wait"}, {127'b0, in_rdy}, 128'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    logic [127:0] held;
    string nm;
    nm = $sformatf("vec%0d", idx);
    wait_rdy(nm);
    in_data    = v.dat;
    in_lane_en = v.en;
    in_vld     = 1'b1;
    out_rdy    = 1'b0;
    step();
    in_vld = 1'b0;
    chk({nm, "_rdy_after_acc"}, {127'b0, in_rdy}, 128'd0);
    cyc = 1;
    while (!out_vld && cyc < 20) begin
      step();
      cyc++;
    end
    chk({nm, "_latency"}, 128'(cyc), 128'(1 + v.d));
    chk({nm, "_data"}, out_data, v.exp_dat);
`ifdef FCNVT_HTOS_FFLAGS_EN
    chk({nm, "_fflags"}, {123'b0, out_fflags}, {123'b0, v.nv, 4'b0});
`endif
    held = out_data;
    for (int s = 0; s < v.stall; s++) begin
      step();
      chk({nm, "_hold_vld"}, {127'b0, out_vld}, 128'd1);
      chk({nm, "_hold_data"}, out_data, held);
      chk({nm, "_hold_rdy"}, {127'b0, in_rdy}, 128'd0);
    end
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    chk({nm, "_vld_after_hs"}, {127'b0, out_vld}, 128'd0);
    chk({nm, "_rdy_after_hs"}, {127'b0, in_rdy}, 128'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // {dat, en, expected out_data, D, NV, stall cycles}
    vecs[0] = '{64'h3C00_3C00_3C00_3C00, 4'hF,
                128'h3F800000_3F800000_3F800000_3F800000, 0, 1'b0, 0};
    vecs[1] = '{64'h8000_03FF_0200_0001, 4'hF,
                128'h80000000_387FC000_38000000_33800000, 3, 1'b0, 0};
    vecs[2] = '{64'h3C00_FE00_7C01_7C00, 4'hF,
                128'h3F800000_FFC00000_7FC02000_7F800000, 0, 1'b1, 0};
    vecs[3] = '{64'h0001_0001_0001_3C00, 4'b0101,
                128'h00000000_33800000_00000000_3F800000, 1, 1'b0, 5};
    vecs[4] = '{64'h0400_7BFF_0155_8001, 4'hF,
                128'h38800000_477FE000_37AA8000_B3800000, 2, 1'b0, 2};
    vecs[5] = '{64'h03FF_03FF_03FF_03FF, 4'h0,
                128'h0, 0, 1'b0, 0};

    cpurst = 1'b1; cnvt_flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    in_data = '0; in_lane_en = '0;
    step(); step(); step();
    chk("reset_vld", {127'b0, out_vld}, 128'd0);
    chk("reset_data", out_data, 128'd0);
    chk("reset_rdy", {127'b0, in_rdy}, 128'd0);
`ifdef FCNVT_HTOS_FFLAGS_EN
    chk("reset_fflags", {123'b0, out_fflags}, 128'd0);
`endif
    cpurst = 1'b0;
    #1;
    chk("rdy_after_reset", {127'b0, in_rdy}, 128'd1);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Flush in the second SCAN cycle of a 4-subnormal request.
    wait_rdy("flush_scan");
    in_data = 64'h0001_0001_0001_0001; in_lane_en = 4'hF; in_vld = 1'b1;
    step();
    in_vld = 1'b0;
    step();
    cnvt_flush = 1'b1;
    #1;
    chk("flush_scan_rdy_during", {127'b0, in_rdy}, 128'd0);
    step();
    cnvt_flush = 1'b0;
    #1;
    chk("flush_scan_idle_rdy", {127'b0, in_rdy}, 128'd1);
    chk("flush_scan_vld", {127'b0, out_vld}, 128'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("flush_scan_no_vld", {127'b0, out_vld}, 128'd0);
    end

    // Flush together with in_vld: request must be ignored.
    in_data = 64'h3C00_3C00_3C00_3C00; in_lane_en = 4'hF;
    in_vld = 1'b1; cnvt_flush = 1'b1;
    #1;
    chk("flush_vld_rdy", {127'b0, in_rdy}, 128'd0);
    step();
    in_vld = 1'b0; cnvt_flush = 1'b0;
    #1;
    chk("flush_vld_idle", {127'b0, in_rdy}, 128'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_vld_no_vld", {127'b0, out_vld}, 128'd0);
    end

    // Reset while a result is waiting in DONE.
    wait_rdy("rst_done");
    in_data = 64'h3C00_3C00_3C00_3C00; in_lane_en = 4'hF; in_vld = 1'b1; out_rdy = 1'b0;
    step();
    in_vld = 1'b0;
    step();
    chk("rst_done_vld_before", {127'b0, out_vld}, 128'd1);
    chk("rst_done_data_before", out_data, 128'h3F800000_3F800000_3F800000_3F800000);
    cpurst = 1'b1;
    #1;
    chk("rst_done_rdy_during", {127'b0, in_rdy}, 128'd0);
    step();
    chk("rst_done_vld", {127'b0, out_vld}, 128'd0);
    chk("rst_done_data", out_data, 128'd0);
    cpurst = 1'b0;
    #1;
    chk("rst_done_rdy_after", {127'b0, in_rdy}, 128'd1);

    // Normal traffic still works after the reset.
    run_vec(10, vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
